// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: width helpers and default parameters shared by the pipelined adder tree.
package adder_tree_pkg;
    localparam int DEF_NUM_INPUTS = 8;
    localparam int DEF_IN_WIDTH = 8;
    localparam int DEF_ACC_WIDTH = 24;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int levels(input int n);
        return clog2(n);
    endfunction
    function automatic int sum_width(input int n, input int w);
        return w + clog2(n);
    endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered tree level, N_IN operands in, N_IN/2 pairwise sums (one bit wider) out.
// HOLD=1 makes the data register load only on valid and clear on reset, for use as the output stage.
module adder_tree_level #(
    parameter int N_IN = 2,
    parameter int W_IN = 8,
    parameter bit SIGNED = 1'b0,
    parameter bit HOLD = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_IN*W_IN-1:0]         in_data,
    input  logic                         in_valid,
    output logic [N_IN/2*(W_IN+1)-1:0]   out_data,
    output logic                         out_valid
);
    logic [N_IN/2*(W_IN+1)-1:0] sums;
    for (genvar i = 0; i < N_IN / 2; i++) begin : p
        logic [W_IN-1:0] a, b;
        assign a = in_data[2*i*W_IN +: W_IN];
        assign b = in_data[(2*i+1)*W_IN +: W_IN];
        assign sums[i*(W_IN+1) +: W_IN+1] = {SIGNED & a[W_IN-1], a} + {SIGNED & b[W_IN-1], b};
    end
    always_ff @(posedge clk) begin
        out_valid <= reset ? 1'b0 : in_valid;
        if (HOLD && reset) out_data <= '0;
        else if (!HOLD || in_valid) out_data <= sums;
    end
endmodule

// File: rtl/adder_tree_pipelined.sv
// adder_tree_pipelined: fully pipelined NUM_INPUTS-operand adder tree, one register stage per level.
// Define ADDER_TREE_ACCUM_EN to add a grouped accumulator stage driven by acc_first/acc_last.
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int SIGNED = 0,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    input  logic                             acc_first,
    input  logic                             acc_last,
`ifdef ADDER_TREE_ACCUM_EN
    output logic [ACC_WIDTH-1:0]             sum_out,
`else
    output logic [sum_width(NUM_INPUTS, IN_WIDTH)-1:0] sum_out,
`endif
    output logic                             out_valid
);
    localparam int LEVELS = levels(NUM_INPUTS);
    localparam int SUM_WIDTH = sum_width(NUM_INPUTS, IN_WIDTH);
`ifdef ADDER_TREE_ACCUM_EN
    localparam bit HOLD_LAST = 1'b0;
`else
    localparam bit HOLD_LAST = 1'b1;
`endif
    logic [SUM_WIDTH-1:0] tree_sum;
    logic                 tree_valid;
    for (genvar k = 0; k < LEVELS; k++) begin : g
        localparam int N = NUM_INPUTS >> k;
        localparam int W = IN_WIDTH + k;
        localparam bit H = (k == LEVELS - 1) && HOLD_LAST;
        logic [N/2*(W+1)-1:0] d;
        logic                 v;
        if (k == 0) begin : h
            adder_tree_level #(.N_IN(N), .W_IN(W), .SIGNED(SIGNED != 0), .HOLD(H)) u_level (
                .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
                .out_data(d), .out_valid(v));
        end else begin : h
            adder_tree_level #(.N_IN(N), .W_IN(W), .SIGNED(SIGNED != 0), .HOLD(H)) u_level (
                .clk(clk), .reset(reset), .in_data(g[k-1].d), .in_valid(g[k-1].v),
                .out_data(d), .out_valid(v));
        end
    end
    assign tree_sum = g[LEVELS-1].d;
    assign tree_valid = g[LEVELS-1].v;
`ifdef ADDER_TREE_ACCUM_EN
    // Group flags ride a shift register aligned with the tree levels.
    logic [1:0]           flags [LEVELS];
    logic [ACC_WIDTH-1:0] acc, ext_sum, acc_next;
    always_ff @(posedge clk) begin
        flags[0] <= {acc_first, acc_last};
        for (int i = 1; i < LEVELS; i++) flags[i] <= flags[i-1];
    end
    assign ext_sum = (SIGNED != 0) ? ACC_WIDTH'($signed(tree_sum)) : ACC_WIDTH'(tree_sum);
    assign acc_next = (flags[LEVELS-1][1] ? '0 : acc) + ext_sum;
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            sum_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= tree_valid & flags[LEVELS-1][0];
            if (tree_valid) acc <= acc_next;
            if (tree_valid && flags[LEVELS-1][0]) sum_out <= acc_next;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{acc_first, acc_last, ACC_WIDTH[0]};
    assign sum_out = tree_sum;
    assign out_valid = tree_valid;
`endif
endmodule

// File: tb/tb_adder_tree_pipelined.sv
// tb_adder_tree_pipelined: directed self-checking bench for adder_tree_pipelined (8 x 8-bit operands).
// Accumulator scenarios run only when ADDER_TREE_ACCUM_EN is defined.
module tb_adder_tree_pipelined;
    localparam int N = 8;
    localparam int W = 8;
`ifdef ADDER_TREE_ACCUM_EN
    localparam int LAT = 4;
    localparam int OW = 24;
    localparam int OW2 = 12;
`else
    localparam int LAT = 3;
    localparam int OW = 11;
    localparam int OW2 = 11;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic acc_first = 1'b1;
    logic acc_last = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [OW-1:0] s0, s1;
    logic [OW2-1:0] s2;
    logic v0, v1, v2;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_tree_pipelined #(.NUM_INPUTS(N), .IN_WIDTH(W), .SIGNED(0), .ACC_WIDTH(24)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .sum_out(s0), .out_valid(v0));
    adder_tree_pipelined #(.NUM_INPUTS(N), .IN_WIDTH(W), .SIGNED(1), .ACC_WIDTH(24)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .sum_out(s1), .out_valid(v1));
    adder_tree_pipelined #(.NUM_INPUTS(N), .IN_WIDTH(W), .SIGNED(0), .ACC_WIDTH(12)) u2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .sum_out(s2), .out_valid(v2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [W-1:0] val);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = val;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        fill(8'd7);
        repeat (2) tick;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_v0 got=%b want=0", v0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_v1 got=%b want=0", v1); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL reset_v2 got=%b want=0", v2); end
        checks++; if (s0 !== '0) begin errors++; $display("FAIL reset_s0 got=%0d want=0", s0); end
        checks++; if (s1 !== '0) begin errors++; $display("FAIL reset_s1 got=%0d want=0", s1); end
        checks++; if (s2 !== '0) begin errors++; $display("FAIL reset_s2 got=%0d want=0", s2); end
        in_valid = 1'b0;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_unsigned_max;
        fill(8'hFF);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            if (c > 1) tick;
            checks++;
            if (v0 !== (c == LAT)) begin errors++; $display("FAIL max_valid tick=%0d got=%b want=%b", c, v0, c == LAT); end
        end
        checks++; if (s0 !== OW'(2040)) begin errors++; $display("FAIL max_unsigned got=%0d want=2040", s0); end
        checks++; if (s1 !== OW'(-8)) begin errors++; $display("FAIL max_as_signed got=%h want=%h", s1, OW'(-8)); end
    endtask

    task automatic test_signed;
        int mix[8] = '{-1, 2, -3, 4, -5, 6, -7, 8};
        fill(8'h80);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (LAT - 1) tick;
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL neg_valid got=%b want=1", v1); end
        checks++; if (s1 !== OW'(-1024)) begin errors++; $display("FAIL neg_signed got=%h want=%h", s1, OW'(-1024)); end
        checks++; if (s0 !== OW'(1024)) begin errors++; $display("FAIL neg_unsigned got=%0d want=1024", s0); end
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(i + 1);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (LAT - 1) tick;
        checks++; if (s1 !== OW'(36)) begin errors++; $display("FAIL ramp_signed got=%0d want=36", s1); end
        checks++; if (s0 !== OW'(36)) begin errors++; $display("FAIL ramp_unsigned got=%0d want=36", s0); end
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(mix[i]);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (LAT - 1) tick;
        checks++; if (s1 !== OW'(4)) begin errors++; $display("FAIL mix_signed got=%0d want=4", s1); end
        checks++; if (s0 !== OW'(1028)) begin errors++; $display("FAIL mix_unsigned got=%0d want=1028", s0); end
        tick;
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL mix_pulse got=%b want=0", v1); end
        checks++; if (s1 !== OW'(4)) begin errors++; $display("FAIL mix_hold got=%0d want=4", s1); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [4] = '{8'd1, 8'd2, 8'd0, 8'd3};
        logic vv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int ss [4] = '{8, 16, 16, 24};
        for (int k = 1; k <= LAT + 5; k++) begin
            if (k <= 4) begin
                fill(vals[k-1]);
                in_valid = vv[k-1];
            end else in_valid = 1'b0;
            tick;
            if (k - LAT >= 0 && k - LAT < 4) begin
                checks++;
                if (v0 !== vv[k-LAT]) begin errors++; $display("FAIL b2b_valid tick=%0d got=%b want=%b", k, v0, vv[k-LAT]); end
                checks++;
                if (s0 !== OW'(ss[k-LAT])) begin errors++; $display("FAIL b2b_sum tick=%0d got=%0d want=%0d", k, s0, ss[k-LAT]); end
            end else if (k > LAT) begin
                checks++;
                if (v0 !== 1'b0) begin errors++; $display("FAIL b2b_tail tick=%0d got=%b want=0", k, v0); end
            end
        end
    endtask

    task automatic test_reset_flush;
        fill(8'd5);
        in_valid = 1'b1;
        tick;
        fill(8'd6);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        in_valid = 1'b0;
        for (int k = 2; k <= LAT + 3; k++) begin
            tick;
            checks++;
            if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL flush_valid tick=%0d got=%b%b want=00", k, v0, v1); end
        end
        checks++; if (s0 !== '0) begin errors++; $display("FAIL flush_sum got=%0d want=0", s0); end
    endtask

`ifdef ADDER_TREE_ACCUM_EN
    task automatic test_accum;
        logic [7:0] vals [4] = '{8'd1, 8'd1, 8'd1, 8'd2};
        logic ff [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic ll [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int ss [4] = '{0, 0, 24, 16};
        for (int k = 1; k <= LAT + 5; k++) begin
            if (k <= 4) begin
                fill(vals[k-1]);
                acc_first = ff[k-1];
                acc_last = ll[k-1];
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick;
            if (k - LAT >= 0 && k - LAT < 4) begin
                checks++;
                if (v0 !== ll[k-LAT]) begin errors++; $display("FAIL acc_valid tick=%0d got=%b want=%b", k, v0, ll[k-LAT]); end
                if (ll[k-LAT]) begin
                    checks++;
                    if (s0 !== OW'(ss[k-LAT])) begin errors++; $display("FAIL acc_sum tick=%0d got=%0d want=%0d", k, s0, ss[k-LAT]); end
                end
            end else if (k > LAT) begin
                checks++;
                if (v0 !== 1'b0) begin errors++; $display("FAIL acc_tail tick=%0d got=%b want=0", k, v0); end
            end
        end
        acc_first = 1'b1;
        acc_last = 1'b1;
    endtask

    task automatic test_accum_wrap;
        logic ff [3] = '{1'b1, 1'b0, 1'b0};
        logic ll [3] = '{1'b0, 1'b0, 1'b1};
        fill(8'hFF);
        for (int j = 0; j < 3; j++) begin
            acc_first = ff[j];
            acc_last = ll[j];
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        in_data = '0;
        repeat (LAT - 1) tick;
        checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b want=1", v2); end
        checks++; if (s2 !== OW2'(2024)) begin errors++; $display("FAIL wrap_sum12 got=%0d want=2024", s2); end
        checks++; if (s0 !== OW'(6120)) begin errors++; $display("FAIL wrap_sum24 got=%0d want=6120", s0); end
        checks++; if (s1 !== OW'(-24)) begin errors++; $display("FAIL wrap_signed got=%h want=%h", s1, OW'(-24)); end
        acc_first = 1'b1;
        acc_last = 1'b1;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_unsigned_max;
        test_signed;
        test_back_to_back;
        test_reset_flush;
`ifdef ADDER_TREE_ACCUM_EN
        test_accum;
        test_accum_wrap;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
